// File: rtl/pac_pkg.sv
// Shared encodings and the default right-facing Pac-Man artwork for the sprite animator.
package pac_pkg;

  typedef enum logic [1:0] {
    ROT_RIGHT = 2'd0,
    ROT_UP    = 2'd1,
    ROT_LEFT  = 2'd2,
    ROT_DOWN  = 2'd3
  } heading_e;

  typedef enum logic [1:0] {
    ANIM_HOLD     = 2'd0,
    ANIM_LOOP     = 2'd1,
    ANIM_PINGPONG = 2'd2
  } anim_mode_e;

  localparam int PAC_SIZE     = 5;
  localparam int PAC_N_FRAMES = 3;

  // Frame 0 closed, frame 1 half open, frame 2 wide open; row 0 col 0 is the MSB of each frame.
  localparam logic [PAC_N_FRAMES*PAC_SIZE*PAC_SIZE-1:0] PAC_FRAMES_5x5 = {
    25'b01110_11100_11000_11100_01110,
    25'b01110_11111_11100_11111_01110,
    25'b01110_11111_11111_11111_01110
  };

endpackage

// File: rtl/pac_sprite_rotate.sv
// Pure wiring: re-maps a right-facing square bitmap to one of the four headings.
module pac_sprite_rotate
  import pac_pkg::*;
#(
  parameter int SIZE = 5
) (
  input  logic [SIZE*SIZE-1:0] bitmap_i,
  input  logic [1:0]           rotation_i,
  output logic [SIZE*SIZE-1:0] bitmap_o
);

  localparam int NPIX = SIZE * SIZE;

  logic [NPIX-1:0] up_w;
  logic [NPIX-1:0] left_w;
  logic [NPIX-1:0] down_w;

  // Flat index of pixel (r,c) is NPIX-1-(r*SIZE+c) because row 0 col 0 sits at the MSB.
  for (genvar r = 0; r < SIZE; r++) begin : g_row
    for (genvar c = 0; c < SIZE; c++) begin : g_col
      localparam int O = NPIX - 1 - (r * SIZE + c);
      assign up_w[O]   = bitmap_i[NPIX - 1 - (c * SIZE + (SIZE - 1 - r))];
      assign left_w[O] = bitmap_i[NPIX - 1 - (r * SIZE + (SIZE - 1 - c))];
      assign down_w[O] = bitmap_i[NPIX - 1 - ((SIZE - 1 - c) * SIZE + r)];
    end
  end

  always_comb begin
    bitmap_o = bitmap_i;
    case (rotation_i)
      ROT_UP:   bitmap_o = up_w;
      ROT_LEFT: bitmap_o = left_w;
      ROT_DOWN: bitmap_o = down_w;
      default:  bitmap_o = bitmap_i;
    endcase
  end

endmodule

// File: rtl/pac_sprite_animator.sv
// Sprite animation sequencer: tick divider, hold/loop/ping-pong frame FSM, heading-change
// restart and a registered, heading-corrected bitmap for the blitter.
module pac_sprite_animator
  import pac_pkg::*;
#(
  parameter int SIZE     = 5,
  parameter int N_FRAMES = 3,
  parameter int TICK_DIV = 4,
  parameter logic [N_FRAMES*SIZE*SIZE-1:0] FRAME_DATA = PAC_FRAMES_5x5,
  localparam int FW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic [1:0]           rotation,
  input  logic [1:0]           mode,
  output logic [SIZE*SIZE-1:0] out,
  output logic [FW-1:0]        frame,
  output logic                 wrap
);

  localparam int              NPIX     = SIZE * SIZE;
  localparam int              DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [FW-1:0]   LAST     = FW'(N_FRAMES - 1);
  localparam logic [DW-1:0]   DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0]   div_q, div_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic            dir_q, dir_d;
  logic [1:0]      rot_q, rot_d;
  logic            wrap_q, wrap_d;
  logic [NPIX-1:0] out_q, out_d;
  logic [NPIX-1:0] src_bitmap;

  logic            ticking;
  logic            advance;
  logic            heading_chg;
  logic            going_down;
  logic [FW-1:0]   pp_step;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    div_d       = div_q;
    frame_d     = frame_q;
    dir_d       = dir_q;
    rot_d       = rot_q;
    wrap_d      = 1'b0;
    ticking     = enable && (mode == ANIM_LOOP || mode == ANIM_PINGPONG);
    advance     = ticking && (div_q == DIV_LAST);
    heading_chg = (rotation != rot_q);
    // A held dir_dn at either end of the range is overridden so ping-pong never leaves 0..LAST.
    going_down  = dir_q ? (frame_q != '0) : (frame_q == LAST);
    pp_step     = going_down ? frame_q - FW'(1) : frame_q + FW'(1);

    if (heading_chg) begin
      frame_d = '0;
      div_d   = '0;
      dir_d   = 1'b0;
      rot_d   = rotation;
    end else if (advance) begin
      div_d = '0;
      if (N_FRAMES == 1) begin
        wrap_d = 1'b1;
      end else if (mode == ANIM_LOOP) begin
        frame_d = (frame_q == LAST) ? '0 : frame_q + FW'(1);
        wrap_d  = (frame_q == LAST);
      end else begin
        frame_d = pp_step;
        wrap_d  = going_down && (pp_step == '0);
        if (pp_step == LAST)    dir_d = 1'b1;
        else if (pp_step == '0) dir_d = 1'b0;
        else                    dir_d = going_down;
      end
    end else if (ticking) begin
      div_d = div_q + DW'(1);
    end
  end

  // Rendering from next-state frame and live heading keeps out aligned with frame.
  assign src_bitmap = FRAME_DATA[frame_d * NPIX +: NPIX];

  pac_sprite_rotate #(
    .SIZE(SIZE)
  ) u_rotate (
    .bitmap_i   (src_bitmap),
    .rotation_i (rotation),
    .bitmap_o   (out_d)
  );

  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!resetn) begin
      div_q   <= '0;
      frame_q <= '0;
      dir_q   <= 1'b0;
      rot_q   <= ROT_RIGHT;
      wrap_q  <= 1'b0;
      out_q   <= FRAME_DATA[NPIX-1:0];
    end else begin
      div_q   <= div_d;
      frame_q <= frame_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
      wrap_q  <= wrap_d;
      out_q   <= out_d;
    end
  end

  assign out   = out_q;
  assign frame = frame_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_pac_sprite_animator.sv
// Directed, table-driven bench for pac_sprite_animator using three builds of the block.
module tb_pac_sprite_animator;

  typedef struct {
    int         sel;
    logic       en;
    logic [1:0] mode;
    logic [1:0] rot;
    int         exp_frame;
    logic       exp_wrap;
    logic [24:0] exp_out;
  } vec_t;

  localparam logic [24:0] F0    = 25'b01110_11111_11111_11111_01110;
  localparam logic [24:0] F1    = 25'b01110_11111_11100_11111_01110;
  localparam logic [24:0] F2    = 25'b01110_11100_11000_11100_01110;
  localparam logic [24:0] F1_UP = 25'b01010_11011_11111_11111_01110;

  localparam logic [74:0] PIX_FRAMES = {
    25'b00000_00000_00000_00000_10000,
    25'b00000_00010_00000_00000_00000,
    25'b00000_00000_00001_00000_00000
  };

  logic        clock;
  logic        resetn;
  logic        en_a, en_b, en_c;
  logic [1:0]  mode_a, mode_b, mode_c;
  logic [1:0]  rot_a, rot_b, rot_c;
  logic [24:0] out_a, out_b, out_c;
  logic [1:0]  frame_a, frame_b;
  logic [0:0]  frame_c;
  logic        wrap_a, wrap_b, wrap_c;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  pac_sprite_animator dut_a (
    .clock(clock), .resetn(resetn), .enable(en_a), .rotation(rot_a), .mode(mode_a),
    .out(out_a), .frame(frame_a), .wrap(wrap_a)
  );

  pac_sprite_animator #(.SIZE(5), .N_FRAMES(3), .TICK_DIV(1), .FRAME_DATA(PIX_FRAMES)) dut_b (
    .clock(clock), .resetn(resetn), .enable(en_b), .rotation(rot_b), .mode(mode_b),
    .out(out_b), .frame(frame_b), .wrap(wrap_b)
  );

  pac_sprite_animator #(.SIZE(5), .N_FRAMES(1), .TICK_DIV(2), .FRAME_DATA(F0)) dut_c (
    .clock(clock), .resetn(resetn), .enable(en_c), .rotation(rot_c), .mode(mode_c),
    .out(out_c), .frame(frame_c), .wrap(wrap_c)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [24:0] pix(input int r, input int c);
    logic [24:0] v;
    v = '0;
    v[24 - (r * 5 + c)] = 1'b1;
    return v;
  endfunction

  function automatic logic [24:0] img(input int f);
    case (f)
      1:       return F1;
      2:       return F2;
      default: return F0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input int sel, input logic en, input logic [1:0] mode, input logic [1:0] rot,
                     input int f, input logic w, input logic [24:0] o);
    vec_t v;
    v.sel = sel; v.en = en; v.mode = mode; v.rot = rot;
    v.exp_frame = f; v.exp_wrap = w; v.exp_out = o;
    vecs.push_back(v);
  endtask

  // Drives each vector at a falling edge and samples at the following falling edge.
  task automatic run_table(input int lo, input int hi);
    int          act_frame;
    logic        act_wrap;
    logic [24:0] act_out;
    for (int i = lo; i < hi; i++) begin
      en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
      case (vecs[i].sel)
        0:       begin en_a = vecs[i].en; mode_a = vecs[i].mode; rot_a = vecs[i].rot; end
        1:       begin en_b = vecs[i].en; mode_b = vecs[i].mode; rot_b = vecs[i].rot; end
        default: begin en_c = vecs[i].en; mode_c = vecs[i].mode; rot_c = vecs[i].rot; end
      endcase
      @(negedge clock);
      case (vecs[i].sel)
        0:       begin act_frame = int'(frame_a); act_wrap = wrap_a; act_out = out_a; end
        1:       begin act_frame = int'(frame_b); act_wrap = wrap_b; act_out = out_b; end
        default: begin act_frame = int'(frame_c); act_wrap = wrap_c; act_out = out_c; end
      endcase
      check($sformatf("vec%0d frame", i), 32'(act_frame), 32'(vecs[i].exp_frame));
      check($sformatf("vec%0d wrap", i), 32'(act_wrap), 32'(vecs[i].exp_wrap));
      check($sformatf("vec%0d out", i), 32'(act_out), 32'(vecs[i].exp_out));
    end
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
  endtask

  initial begin
    int split_reset;
    int split_end;

    // Build A (TICK_DIV=4, N=3): loop, hold, resume, heading change racing an advance.
    for (int k = 1; k <= 18; k++) add(0, 1, 1, 0, (k / 4) % 3, k == 12, img((k / 4) % 3));
    for (int k = 0; k < 10; k++) add(0, 1, 0, 0, 1, 0, F1);
    add(0, 1, 1, 0, 1, 0, F1);
    add(0, 1, 1, 0, 2, 0, F2);
    for (int k = 0; k < 3; k++) add(0, 1, 1, 0, 2, 0, F2);
    add(0, 1, 1, 0, 0, 1, F0);
    for (int k = 0; k < 3; k++) add(0, 1, 1, 0, 0, 0, F0);
    add(0, 1, 1, 0, 1, 0, F1);
    for (int k = 0; k < 3; k++) add(0, 1, 1, 0, 1, 0, F1);
    add(0, 1, 1, 1, 0, 0, F0);
    add(0, 0, 1, 1, 0, 0, F0);
    for (int k = 0; k < 3; k++) add(0, 1, 1, 1, 0, 0, F0);
    add(0, 1, 1, 1, 1, 0, F1_UP);
    add(0, 0, 1, 1, 1, 0, F1_UP);

    // Build B (TICK_DIV=1, single-pixel frames): headings in hold, then ping-pong.
    add(1, 0, 0, 1, 0, 0, pix(0, 2));
    add(1, 0, 0, 2, 0, 0, pix(2, 0));
    add(1, 0, 0, 3, 0, 0, pix(4, 2));
    add(1, 0, 0, 0, 0, 0, pix(2, 4));
    add(1, 1, 2, 0, 1, 0, pix(1, 3));
    add(1, 1, 2, 0, 2, 0, pix(4, 0));
    add(1, 1, 2, 0, 1, 0, pix(1, 3));
    add(1, 1, 2, 0, 0, 1, pix(2, 4));
    add(1, 1, 2, 0, 1, 0, pix(1, 3));
    add(1, 1, 2, 0, 2, 0, pix(4, 0));
    add(1, 1, 2, 0, 1, 0, pix(1, 3));
    add(1, 1, 2, 0, 0, 1, pix(2, 4));
    add(1, 1, 2, 0, 1, 0, pix(1, 3));
    add(1, 1, 2, 0, 2, 0, pix(4, 0));
    add(1, 0, 2, 0, 2, 0, pix(4, 0));
    split_reset = vecs.size();

    // After the mid-sequence reset: B restarts ascending, then a heading change in hold.
    add(1, 1, 2, 0, 1, 0, pix(1, 3));
    add(1, 0, 0, 2, 0, 0, pix(2, 0));
    // Build C (N_FRAMES=1, TICK_DIV=2): every advance wraps in loop and ping-pong.
    add(2, 1, 1, 0, 0, 0, F0);
    add(2, 1, 1, 0, 0, 1, F0);
    add(2, 1, 1, 0, 0, 0, F0);
    add(2, 1, 1, 0, 0, 1, F0);
    add(2, 1, 2, 0, 0, 0, F0);
    add(2, 1, 2, 0, 0, 1, F0);
    add(2, 0, 2, 0, 0, 0, F0);
    split_end = vecs.size();

    resetn = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    mode_a = 2'd0; mode_b = 2'd0; mode_c = 2'd0;
    rot_a = 2'd0; rot_b = 2'd0; rot_c = 2'd0;
    repeat (2) @(negedge clock);
    check("reset frame_a", 32'(frame_a), 32'd0);
    check("reset wrap_a", 32'(wrap_a), 32'd0);
    check("reset out_a", 32'(out_a), 32'(F0));
    check("reset out_b", 32'(out_b), 32'(pix(2, 4)));
    resetn = 1'b1;

    run_table(0, split_reset);

    // B is at frame 2 descending; reset must clear it without waiting for a clock edge.
    #2 resetn = 1'b0;
    #1;
    check("async frame_b", 32'(frame_b), 32'd0);
    check("async wrap_b", 32'(wrap_b), 32'd0);
    check("async out_b", 32'(out_b), 32'(pix(2, 4)));
    check("async frame_a", 32'(frame_a), 32'd0);
    check("async out_a", 32'(out_a), 32'(F0));
    @(negedge clock);
    resetn = 1'b1;

    run_table(split_reset, split_end);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pac_sprite_animator.md
# pac_sprite_animator

Parametrised sprite animation sequencer for the Pac-Man renderer. It steps through `N_FRAMES` square `SIZE`×`SIZE` bitmaps at a programmable rate, in hold, loop or ping-pong order. Right-facing frames are supplied once and rotated or mirrored on the fly for the up, left and down headings. It sits between the game-tick generator and the sprite blitter, and its registered bitmap output feeds the blitter directly.

## Interface
- `SIZE`, 5: sprite edge in pixels. Bitmap is row-major, bit `[SIZE*SIZE-1]` = row 0 col 0 (top-left).
- `N_FRAMES`, 3: number of animation frames, ≥1.
- `TICK_DIV`, 4: `enable` pulses per frame advance, ≥1.
- `FRAME_DATA`, `PAC_FRAMES_5x5` (package): right-facing frames; frame f = `[f*SIZE*SIZE +: SIZE*SIZE]`.
- `clock` in 1: rising-edge clock.
- `resetn` in 1: asynchronous, active-low reset.
- `enable` in 1: game-tick pulse, 1 cycle wide.
- `rotation` in 2: heading. 0 right, 1 up, 2 left, 3 down.
- `mode` in 2: 0 hold, 1 loop, 2 ping-pong, 3 treated as hold.
- `out` out `SIZE*SIZE`: registered bitmap of the current frame at the current heading.
- `frame` out `$clog2(N_FRAMES)` (min 1): current frame index.
- `wrap` out 1: 1-cycle pulse when a sequence cycle completes.

## Operation
- State: `div_cnt` (0..TICK_DIV-1), `frame` (0..N_FRAMES-1), `dir_dn` (ping-pong direction), `rot_q` (last heading).
- Advance condition: `enable && mode∈{1,2} && div_cnt==TICK_DIV-1`. `div_cnt` increments on each `enable` in modes 1/2 and resets to 0 on an advance. Hold freezes `div_cnt`, `frame` and `dir_dn`.
- Loop: frame+1; N_FRAMES-1 → 0 with `wrap`=1.
- Ping-pong: ascend to N_FRAMES-1, set `dir_dn`, descend to 0, clear `dir_dn`. `wrap`=1 on the advance that lands on 0. Sequence for N=3: 0,1,2,1,0,1…
- N_FRAMES=1: frame stays 0, and every advance asserts `wrap`.
- Heading change (`rotation != rot_q`): `frame`←0, `div_cnt`←0, `dir_dn`←0, `rot_q`←`rotation`, `wrap`=0. This has priority over a same-cycle advance.
- Mode change: takes effect next cycle. `frame` and `div_cnt` are kept. Ping-pong→loop while descending continues ascending from the current frame. Loop→ping-pong uses the held `dir_dn`.
- Rotation mapping, with o(r,c) taken from i(·,·) and S=SIZE:
  - right: i(r,c)
  - up: i(c,S-1-r)
  - left: i(r,S-1-c), a mirror so the eye stays on top
  - down: i(S-1-c,r)

## Timing
- Async reset: `frame`=0, `div_cnt`=0, `dir_dn`=0, `rot_q`=0, `wrap`=0, `out`=frame 0 unrotated. Release is synchronous to `clock`.
- `out`, `frame` and `wrap` are all registered. `out` is computed from the next-state frame and the live `rotation`, so `out` always matches `frame` and the heading in the same cycle.
- Latency: 1 cycle from the advancing `enable` or a `rotation` change to the new `out`.
- A `rotation` change during hold still forces frame 0 and re-renders.
- Reset asserted mid-sequence clears all state immediately, with no completion of a pending advance.

## Structure
- Package `pac_pkg`: heading encoding constants (`ROT_RIGHT..ROT_DOWN`), mode constants (`ANIM_HOLD/LOOP/PINGPONG`), and `PAC_FRAMES_5x5`.
- Sub-module `pac_sprite_rotate`: combinational, params `SIZE`; in: bitmap and `rotation`; out: transformed bitmap. It is generate-loop index mapping only.
- Top: divider, frame/direction FSM, heading-change detect, output register.

## Test plan
- Reset, TICK_DIV=4, N=3, loop: 12 `enable` pulses → frame 0→1→2→0 on every 4th pulse; `wrap` pulses once on the 12th; `out` equals FRAME_DATA slices.
- Ping-pong, TICK_DIV=1, N=3: 8 pulses → frames 1,2,1,0,1,2,1,0; `wrap` on pulses 4 and 8.
- Rotation with a single-pixel frame at (2,4), SIZE=5: rotation 0/1/2/3 → the lit pixel is at (2,4)/(0,2)/(2,0)/(4,2).
- Heading change on the same cycle as an advance from frame 1 → frame=0, `div_cnt`=0, `wrap`=0, `out` = frame 0 at the new heading.
- Hold mode with 10 pulses → frame and `out` unchanged. Switch to loop → the first advance occurs after TICK_DIV-`div_cnt` pulses.
- Assert `resetn` low mid-sequence at frame 2 while descending → all outputs return to reset values with no clock edge. N_FRAMES=1 build: `wrap` fires on every advance.
